// File: rtl/tdm_demux_1_4_pkg.sv
// Shared TDM framing definitions, used by both the receive-side demux and the
// transmit-side mux sequencer.
package tdm_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

  // Slot index that follows s within a frame, wrapping after the last lane.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    return (s == SLOT_W'(LANES - 1)) ? '0 : s + SLOT_W'(1);
  endfunction

endpackage

// File: rtl/tdm_demux_1_4_if.sv
// TDM beat stream into the demux plus the rebuilt-frame and framing status
// signals coming back out of it.
interface tdm_demux_1_4_if
  import tdm_pkg::*;
#(
  parameter int unsigned W = 1
);

  logic [W-1:0]       din;
  logic               din_valid;
  logic               frame_start;
  logic [LANES*W-1:0] lanes;
  logic               lanes_valid;
  logic [SLOT_W-1:0]  slot;
  logic               locked;
  logic               sync_err;

  // Stream source and frame consumer side.
  modport master (
    output din, din_valid, frame_start,
    input  lanes, lanes_valid, slot, locked, sync_err
  );

  // Demux side.
  modport slave (
    input  din, din_valid, frame_start,
    output lanes, lanes_valid, slot, locked, sync_err
  );

endinterface

// File: rtl/tdm_demux_1_4.sv
// 1:4 TDM demultiplexer: aligns on the frame marker, collects slots 0..2 in a
// shadow register and publishes the whole frame when the slot-3 beat arrives.
module tdm_demux_1_4
  import tdm_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input logic              clk,
  input logic              rst,
  tdm_demux_1_4_if.slave   bus
);

  tdm_state_e               state;
  logic [SLOT_W-1:0]        slot_q;
  logic [LANES-2:0][W-1:0]  shadow;
  logic [LANES*W-1:0]       lanes_q;
  logic                     lanes_valid_q;
  logic                     locked_q;
  logic                     sync_err_q;

  // Framing FSM, slot counter, shadow and output registers in one place so
  // every output is a flop updated on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HUNT;
      slot_q        <= '0;
      shadow        <= '0;
      lanes_q       <= '0;
      lanes_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      lanes_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (bus.din_valid) begin
        unique case (state)
          HUNT: begin
            // Anything before the first marker is discarded.
            if (bus.frame_start) begin
              shadow[0] <= bus.din;
              slot_q    <= SLOT_W'(1);
              state     <= RUN;
              locked_q  <= 1'b1;
            end
          end
          RUN: begin
            if (bus.frame_start) begin
              // A marker anywhere but slot 0 abandons the partial frame; the
              // stale shadow entries are overwritten before lanes can see them.
              if (slot_q != '0) begin
                sync_err_q <= 1'b1;
              end
              shadow[0] <= bus.din;
              slot_q    <= SLOT_W'(1);
            end else if (slot_q == '0) begin
              sync_err_q <= 1'b1;
              state      <= HUNT;
              locked_q   <= 1'b0;
            end else if (slot_q == SLOT_W'(LANES - 1)) begin
              lanes_q       <= {bus.din, shadow};
              lanes_valid_q <= 1'b1;
              slot_q        <= next_slot(slot_q);
            end else begin
              shadow[slot_q] <= bus.din;
              slot_q         <= next_slot(slot_q);
            end
          end
          default: begin
            state    <= HUNT;
            locked_q <= 1'b0;
            slot_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.lanes       = lanes_q;
  assign bus.lanes_valid = lanes_valid_q;
  assign bus.slot        = slot_q;
  assign bus.locked      = locked_q;
  assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Scoreboard bench for tdm_demux_1_4: a frame-collecting reference model
// queues expected lanes/sync_err events; a monitor pops them as they appear.
module tb_tdm_demux_1_4;

  localparam int unsigned W = 4;
  localparam int unsigned N = 4;

  typedef struct {
    bit               is_err;
    logic [N*W-1:0]   lanes;
    int               due;
  } ev_t;

  logic clk;
  logic rst;
  tdm_demux_1_4_if #(.W(W)) bus ();

  tdm_demux_1_4 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: the beats gathered so far in the current frame.
  logic [W-1:0]   frame_q[$];
  bit             aligned;
  logic [N*W-1:0] m_lanes;
  ev_t            exp_q[$];

  function automatic void model_reset();
    frame_q.delete();
    aligned = 1'b0;
    m_lanes = '0;
    exp_q.delete();
  endfunction

  function automatic void push_ev(bit is_err, logic [N*W-1:0] l);
    ev_t e;
    e.is_err = is_err;
    e.lanes  = l;
    e.due    = cyc + 1;
    exp_q.push_back(e);
  endfunction

  function automatic void model_beat(logic [W-1:0] d, bit fs);
    logic [N*W-1:0] t;
    if (!aligned) begin
      if (fs) begin
        frame_q.delete();
        frame_q.push_back(d);
        aligned = 1'b1;
      end
    end else if (fs) begin
      if (frame_q.size() != 0) push_ev(1'b1, m_lanes);
      frame_q.delete();
      frame_q.push_back(d);
    end else if (frame_q.size() == 0) begin
      push_ev(1'b1, m_lanes);
      aligned = 1'b0;
    end else begin
      frame_q.push_back(d);
      if (frame_q.size() == N) begin
        t = '0;
        for (int k = 0; k < N; k++) t[k*W +: W] = frame_q[k];
        m_lanes = t;
        push_ev(1'b0, t);
        frame_q.delete();
      end
    end
  endfunction

  // Drive one cycle of stimulus on the falling edge and update the model.
  task automatic step(input bit v, input bit fs, input logic [W-1:0] d);
    @(negedge clk);
    rst             = 1'b0;
    bus.din_valid   = v;
    bus.frame_start = fs;
    bus.din         = d;
    if (v) model_beat(d, fs);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst             = 1'b1;
      bus.din_valid   = $urandom_range(0, 1);
      bus.frame_start = $urandom_range(0, 1);
      bus.din         = W'($urandom);
      model_reset();
    end
  endtask

  task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] e,
                       input int gap);
    logic [W-1:0] bt[4];
    bt[0] = a; bt[1] = b; bt[2] = c; bt[3] = e;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, bt[i]);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, W'($urandom));
    end
  endtask

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  always @(posedge clk) begin
    ev_t e;
    cyc = cyc + 1;
    #1;
    checks++;
    if (bus.slot !== 2'(frame_q.size())) begin
      errors++;
      $display("FAIL slot cyc=%0d got=%0d exp=%0d", cyc, bus.slot, frame_q.size());
    end
    checks++;
    if (bus.locked !== aligned) begin
      errors++;
      $display("FAIL locked cyc=%0d got=%0b exp=%0b", cyc, bus.locked, aligned);
    end
    checks++;
    if (bus.lanes !== m_lanes) begin
      errors++;
      $display("FAIL lanes cyc=%0d got=%h exp=%h", cyc, bus.lanes, m_lanes);
    end
    if (bus.lanes_valid === 1'b1 || bus.sync_err === 1'b1) begin
      checks++;
      if (bus.lanes_valid === 1'b1 && bus.sync_err === 1'b1) begin
        errors++;
        $display("FAIL both_pulses cyc=%0d got=11 exp=one_of", cyc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got lv=%0b se=%0b exp=none",
                 cyc, bus.lanes_valid, bus.sync_err);
      end else begin
        e = exp_q.pop_front();
        if (e.due != cyc || e.is_err != bus.sync_err ||
            (!e.is_err && bus.lanes !== e.lanes)) begin
          errors++;
          $display("FAIL event cyc=%0d got se=%0b lanes=%h exp se=%0b lanes=%h due=%0d",
                   cyc, bus.sync_err, bus.lanes, e.is_err, e.lanes, e.due);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL missing_event cyc=%0d got lv=0 se=0 exp se=%0b lanes=%h",
               cyc, e.is_err, e.lanes);
    end
  end

  initial begin
    int fs_err;
    rst             = 1'b1;
    bus.din_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.din         = '0;
    model_reset();

    do_reset(2);
    step(1'b0, 1'b0, '0);

    // Single frame 0,1,1,1.
    frame(4'h0, 4'h1, 4'h1, 4'h1, 0);
    step(1'b0, 1'b0, '0);

    // Beats before the marker are ignored, then 1,0,1,0.
    do_reset(1);
    step(1'b1, 1'b0, 4'h1);
    step(1'b1, 1'b0, 4'h1);
    frame(4'h1, 4'h0, 4'h1, 4'h0, 0);

    // Two idle cycles between every beat.
    frame(4'h1, 4'h1, 4'h0, 4'h0, 2);

    // Early marker at slot 2, then a full frame.
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h1);
    frame(4'h0, 4'h0, 4'h0, 4'h1, 0);

    // Missing marker right after a good frame.
    frame(4'hA, 4'hB, 4'hC, 4'hD, 0);
    step(1'b1, 1'b0, 4'h7);
    step(1'b0, 1'b0, '0);

    // Reset part-way through a frame.
    step(1'b1, 1'b1, 4'h3);
    step(1'b1, 1'b0, 4'h4);
    step(1'b1, 1'b0, 4'h5);
    do_reset(1);
    step(1'b1, 1'b0, 4'h6);
    step(1'b0, 1'b0, '0);

    // Back-to-back frames with full-width data.
    for (int f = 0; f < 4; f++)
      frame(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0);

    // Random traffic: mostly well-formed framing with occasional violations,
    // idle cycles and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else if ($urandom_range(0, 4) == 0) begin
        step(1'b0, 1'($urandom), W'($urandom));
      end else begin
        fs_err = ($urandom_range(0, 19) == 0) ? 1 : 0;
        step(1'b1, ((frame_q.size() == 0) ? 1'b1 : 1'b0) ^ 1'(fs_err), W'($urandom));
      end
    end

    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
